hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Stall/flush side of pipeline hazard handling; complements the E-stage forwarding unit.
//  - Detects load-use hazards that forwarding cannot cover.
//  - Flushes wrong-path instructions on taken branches/jumps.
//  - Freezes the pipeline while data memory has not acknowledged an M-stage access.
//  - Flags a memory timeout.
//  - Keeps saturating performance counters for each hazard class.
// PARAMETERS
//  REG_W    5    register index width
//  CNT_W    32   performance counter width
//  TIMEOUT  255  MEM_WAIT cycles tolerated before error; >=1; wait counter is $clog2(TIMEOUT+1) bits
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous reset, active low
//  Rs1D        in   REG_W  source register 1 of instruction in D
//  Rs2D        in   REG_W  source register 2 of instruction in D
//  RdE         in   REG_W  destination register of instruction in E
//  RegWriteE   in   1      instruction in E writes the register file
//  ResultSrcE  in   2      E result select; 2'b01 = load (memory data)
//  PCSrcE      in   1      taken branch/jump resolved in E
//  MemReqM     in   1      load/store in M is accessing data memory
//  MemReadyM   in   1      data memory completes the M access this cycle
//  CntClr      in   1      synchronous clear of the performance counters
//  StallF      out  1      hold PC
//  StallD      out  1      hold F/D register
//  StallE      out  1      hold D/E register
//  StallM      out  1      hold E/M register
//  FlushD      out  1      clear F/D register to bubble
//  FlushE      out  1      clear D/E register to bubble
//  FlushW      out  1      clear M/W register to bubble (no duplicate writeback)
//  MemErr      out  1      sticky memory-timeout error
//  LoadUseCnt  out  CNT_W  load-use stall cycles
//  FlushCnt    out  CNT_W  branch flush events
//  MemWaitCnt  out  CNT_W  memory-wait stall cycles
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=RUN, wait counter=0, MemErr=0, all counters 0.
//   - All Stall*/Flush* outputs forced 0 combinationally while rst_n=0.
//  Combinational terms
//   - lwStall = RegWriteE & ResultSrcE==2'b01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D)
//   - memWait = (RUN & MemReqM & !MemReadyM) | (MEM_WAIT & !MemReadyM) | ERROR
//  Output priority (same-cycle, zero latency)
//   1. memWait: StallF=StallD=StallE=StallM=FlushW=1; FlushD=FlushE=0.
//      lwStall and PCSrcE are ignored; E is frozen, so they are re-evaluated next cycle.
//   2. else PCSrcE: FlushD=FlushE=1, all stalls 0 (PCSrcE masks lwStall).
//   3. else lwStall: StallF=StallD=FlushE=1.
//   4. else all 0.
//  FSM
//   RUN:
//    - MemReqM & !MemReadyM -> MEM_WAIT, wait=1.
//   MEM_WAIT:
//    - MemReadyM -> RUN, wait=0; pipeline released that same cycle.
//    - else if wait==TIMEOUT -> ERROR.
//    - else wait+1.
//   ERROR:
//    - MemErr=1; pipeline held frozen; exit only via rst_n.
//  Counters (update at clk edge)
//   - Saturate at all-ones; CntClr has priority over increment; frozen in ERROR.
//   - LoadUseCnt +1 per cycle of priority-3 stall.
//   - FlushCnt +1 per cycle of priority-2 flush.
//   - MemWaitCnt +1 per memWait cycle.
// TESTING
//  1. RdE=5, RegWriteE=1, ResultSrcE=01, Rs1D=5 for 1 cycle
//     -> StallF=StallD=FlushE=1 that cycle, 0 next; LoadUseCnt 0->1.
//  2. Same as 1 but RdE=Rs1D=0, then separately PCSrcE=1 with lwStall true
//     -> no stall; then FlushD=FlushE=1, StallF=0, FlushCnt=1, LoadUseCnt=0.
//  3. MemReqM=1, MemReadyM=0 for 3 cycles, then 1
//     -> StallF/D/E/M=FlushW=1 for 3 cycles, all 0 on 4th; MemWaitCnt=3; FSM back in RUN.
//  4. TIMEOUT=4, MemReqM=1, MemReadyM held 0
//     -> stalls from cycle 1; MemErr=1 from cycle 6 onward, stalls stay 1; MemReadyM=1 later has no effect.
//  5. rst_n pulsed low during MEM_WAIT (async, mid-cycle)
//     -> outputs 0 immediately, counters 0, MemErr=0; after release, FSM in RUN.
//  6. CNT_W=4, 20 load-use cycles with CntClr pulsed at cycle 18
//     -> LoadUseCnt saturates at 15, reads 0 after clear, then 1, 2.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall/flush side of pipeline hazard handling, working alongside the
//   E-stage forwarding unit.
//   - Load-use hazards that forwarding cannot cover stall F/D and bubble E.
//   - Taken branches/jumps resolved in E flush the wrong-path D and E slots.
//   - An unacknowledged data-memory access in M freezes the whole pipeline.
//   - A memory wait longer than TIMEOUT cycles raises a sticky error.
//   - Saturating performance counters track each hazard class.
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   Rs1D, Rs2D                 source registers of the instruction in D
//   RdE, RegWriteE, ResultSrcE destination / write enable / result select in E
//   PCSrcE                     taken branch/jump resolved in E
//   MemReqM, MemReadyM         M-stage memory request and completion
//   CntClr                     synchronous clear of the performance counters
//   StallF/D/E/M               hold PC and pipeline registers
//   FlushD/E/W                 clear F/D, D/E, M/W registers to bubbles
//   MemErr                     sticky memory-timeout error
//   LoadUseCnt, FlushCnt, MemWaitCnt  saturating event counters
module hazard_stall_ctrl #(
    parameter int REG_W   = 5,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             CntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] LoadUseCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] MemWaitCnt
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic              mem_err_r;
    logic [CNT_W-1:0]  lu_cnt_r;
    logic [CNT_W-1:0]  fl_cnt_r;
    logic [CNT_W-1:0]  mw_cnt_r;

    logic              lw_stall_s;
    logic              mem_wait_s;
    logic              lu_evt_s;
    logic              fl_evt_s;
    logic              mw_evt_s;

    // Saturating increment: a counter parked at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Load-use hazard: E loads into a register D reads; x0 never hazards.
    assign lw_stall_s = RegWriteE && (ResultSrcE == 2'b01) &&
                        (RdE != {REG_W{1'b0}}) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Memory freeze: a fresh miss in RUN, an ongoing wait, or the error trap.
    always_comb begin
        mem_wait_s = 1'b0;
        case (state_r)
            ST_RUN:      mem_wait_s = MemReqM && !MemReadyM;
            ST_MEM_WAIT: mem_wait_s = !MemReadyM;
            ST_ERROR:    mem_wait_s = 1'b1;
            default:     mem_wait_s = 1'b0;
        endcase
    end

    // Prioritised stall/flush outputs; all held low while reset is asserted.
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushW   = 1'b0;
        lu_evt_s = 1'b0;
        fl_evt_s = 1'b0;
        mw_evt_s = 1'b0;
        if (!rst_n) begin
            StallF = 1'b0;
        end else if (mem_wait_s) begin
            // E is frozen, so branch and load-use are re-evaluated later.
            StallF   = 1'b1;
            StallD   = 1'b1;
            StallE   = 1'b1;
            StallM   = 1'b1;
            FlushW   = 1'b1;
            mw_evt_s = 1'b1;
        end else if (PCSrcE) begin
            // The load-use victim in D is on the wrong path anyway.
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            fl_evt_s = 1'b1;
        end else if (lw_stall_s) begin
            StallF   = 1'b1;
            StallD   = 1'b1;
            FlushE   = 1'b1;
            lu_evt_s = 1'b1;
        end else begin
            StallF = 1'b0;
        end
    end

    // Next-state logic for the memory-wait tracker.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        case (state_r)
            ST_RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_nxt_s = ST_MEM_WAIT;
                    wait_nxt_s  = WAIT_W'(1);
                end else begin
                    state_nxt_s = ST_RUN;
                    wait_nxt_s  = {WAIT_W{1'b0}};
                end
            end
            ST_MEM_WAIT: begin
                if (MemReadyM) begin
                    state_nxt_s = ST_RUN;
                    wait_nxt_s  = {WAIT_W{1'b0}};
                end else if (wait_r == WAIT_MAX) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    wait_nxt_s = wait_r + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                // Trap: only rst_n leaves this state.
                state_nxt_s = ST_ERROR;
            end
            default: begin
                state_nxt_s = ST_RUN;
                wait_nxt_s  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // FSM state, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            wait_r    <= {WAIT_W{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            wait_r    <= wait_nxt_s;
            mem_err_r <= mem_err_r || (state_nxt_s == ST_ERROR);
        end
    end

    // Performance counters: clear wins over increment; no counting in ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_r <= {CNT_W{1'b0}};
            fl_cnt_r <= {CNT_W{1'b0}};
            mw_cnt_r <= {CNT_W{1'b0}};
        end else if (CntClr) begin
            lu_cnt_r <= {CNT_W{1'b0}};
            fl_cnt_r <= {CNT_W{1'b0}};
            mw_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_ERROR) begin
            if (lu_evt_s) lu_cnt_r <= sat_inc(lu_cnt_r);
            if (fl_evt_s) fl_cnt_r <= sat_inc(fl_cnt_r);
            if (mw_evt_s) mw_cnt_r <= sat_inc(mw_cnt_r);
        end
    end

    assign MemErr     = mem_err_r;
    assign LoadUseCnt = lu_cnt_r;
    assign FlushCnt   = fl_cnt_r;
    assign MemWaitCnt = mw_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (REG_W=5, CNT_W=4, TIMEOUT=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered values 1 unit after the following edge.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic       RegWriteE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemReqM, MemReadyM, CntClr;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [3:0] LoadUseCnt, FlushCnt, MemWaitCnt;
    logic [6:0] outs;

    int total = 0;
    int bad   = 0;

    // Output bundle order: StallF StallD StallE StallM FlushD FlushE FlushW
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100010;
    localparam logic [6:0] O_BR   = 7'b0000110;
    localparam logic [6:0] O_MEM  = 7'b1111001;

    assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    hazard_stall_ctrl #(.REG_W(5), .CNT_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr),
        .LoadUseCnt(LoadUseCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
        RegWriteE = 1'b0; ResultSrcE = 2'b00;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0; CntClr = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        RdE = rd; Rs1D = r1; Rs2D = r2; RegWriteE = 1'b1; ResultSrcE = 2'b01;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        MemReqM = 1'b1; PCSrcE = 1'b1;
        load_use(5'd3, 5'd3, 5'd0);
        rst_n = 1'b0;
        #12;
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs, O_NONE); end
        total++;
        if ({MemErr, LoadUseCnt, FlushCnt, MemWaitCnt} !== 13'd0) begin
            bad++; $display("FAIL reset_regs err=%b lu=%0d fl=%0d mw=%0d want all 0", MemErr, LoadUseCnt, FlushCnt, MemWaitCnt);
        end
        idle();
        #2 rst_n = 1'b1;
        tick();
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL reset_idle got=%b want=%b", outs, O_NONE); end
    endtask

    task automatic test_load_use();
        load_use(5'd5, 5'd5, 5'd0);
        #1;
        total++;
        if (outs !== O_LU) begin bad++; $display("FAIL lu_rs1 got=%b want=%b", outs, O_LU); end
        tick();
        idle();
        #1;
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL lu_release got=%b want=%b", outs, O_NONE); end
        total++;
        if (LoadUseCnt !== 4'd1) begin bad++; $display("FAIL lu_cnt1 got=%0d want=1", LoadUseCnt); end
        load_use(5'd7, 5'd2, 5'd7);
        #1;
        total++;
        if (outs !== O_LU) begin bad++; $display("FAIL lu_rs2 got=%b want=%b", outs, O_LU); end
        tick();
        // Non-load producer (ALU result) is covered by forwarding.
        load_use(5'd7, 5'd7, 5'd0);
        ResultSrcE = 2'b00;
        #1;
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL lu_alu got=%b want=%b", outs, O_NONE); end
        tick();
        total++;
        if (LoadUseCnt !== 4'd2) begin bad++; $display("FAIL lu_cnt2 got=%0d want=2", LoadUseCnt); end
        idle();
    endtask

    task automatic test_flush();
        clear_counters();
        load_use(5'd0, 5'd0, 5'd0);
        #1;
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL x0_nostall got=%b want=%b", outs, O_NONE); end
        tick();
        load_use(5'd5, 5'd5, 5'd5);
        PCSrcE = 1'b1;
        #1;
        total++;
        if (outs !== O_BR) begin bad++; $display("FAIL br_flush got=%b want=%b", outs, O_BR); end
        tick();
        idle();
        total++;
        if ({FlushCnt, LoadUseCnt} !== {4'd1, 4'd0}) begin
            bad++; $display("FAIL br_cnt fl=%0d lu=%0d want fl=1 lu=0", FlushCnt, LoadUseCnt);
        end
    endtask

    task automatic test_mem_wait();
        clear_counters();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            // Branch and load-use on cycle 2 must be ignored under the freeze.
            PCSrcE = (c == 2);
            if (c == 2) load_use(5'd9, 5'd9, 5'd0);
            #1;
            total++;
            if (outs !== O_MEM) begin bad++; $display("FAIL mw_cycle%0d got=%b want=%b", c, outs, O_MEM); end
            tick();
            PCSrcE = 1'b0; RegWriteE = 1'b0;
        end
        MemReadyM = 1'b1;
        #1;
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL mw_release got=%b want=%b", outs, O_NONE); end
        tick();
        total++;
        if ({MemWaitCnt, FlushCnt, LoadUseCnt} !== {4'd3, 4'd0, 4'd0}) begin
            bad++; $display("FAIL mw_cnt mw=%0d fl=%0d lu=%0d want 3/0/0", MemWaitCnt, FlushCnt, LoadUseCnt);
        end
        // Back in RUN: no request means no stall even with ready low.
        MemReqM = 1'b0; MemReadyM = 1'b0;
        #1;
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL mw_run got=%b want=%b", outs, O_NONE); end
        tick();
        idle();
    endtask

    task automatic test_timeout();
        clear_counters();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) MemReadyM = 1'b1;
            #1;
            total++;
            if (outs !== O_MEM) begin bad++; $display("FAIL to_outs c%0d got=%b want=%b", c, outs, O_MEM); end
            total++;
            if (MemErr !== (c >= 6)) begin bad++; $display("FAIL to_err c%0d got=%b want=%b", c, MemErr, (c >= 6)); end
            tick();
        end
        total++;
        if (MemWaitCnt !== 4'd5) begin bad++; $display("FAIL to_cnt got=%0d want=5", MemWaitCnt); end
    endtask

    task automatic test_async_reset();
        // From the ERROR trap, reset mid-cycle clears everything at once.
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({outs, MemErr, MemWaitCnt} !== 12'd0) begin
            bad++; $display("FAIL ar_err outs=%b err=%b mw=%0d want 0", outs, MemErr, MemWaitCnt);
        end
        #1 rst_n = 1'b1;
        tick();
        // Enter MEM_WAIT, then pulse reset mid-cycle.
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick();
        tick();
        #2;
        total++;
        if (outs !== O_MEM) begin bad++; $display("FAIL ar_pre got=%b want=%b", outs, O_MEM); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({outs, MemErr, MemWaitCnt, LoadUseCnt, FlushCnt} !== 20'd0) begin
            bad++; $display("FAIL ar_wait outs=%b err=%b mw=%0d want 0", outs, MemErr, MemWaitCnt);
        end
        MemReqM = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        #1;
        // Still in MEM_WAIT would stall with ready low; RUN does not.
        total++;
        if (outs !== O_NONE) begin bad++; $display("FAIL ar_run got=%b want=%b", outs, O_NONE); end
        idle();
    endtask

    task automatic test_saturation();
        clear_counters();
        load_use(5'd4, 5'd0, 5'd4);
        for (int c = 1; c <= 20; c++) begin
            CntClr = (c == 18);
            tick();
            if (c == 15 || c == 17) begin
                total++;
                if (LoadUseCnt !== 4'd15) begin bad++; $display("FAIL sat_c%0d got=%0d want=15", c, LoadUseCnt); end
            end
            if (c >= 18) begin
                total++;
                if (LoadUseCnt !== 4'(c - 18)) begin bad++; $display("FAIL sat_clr_c%0d got=%0d want=%0d", c, LoadUseCnt, c - 18); end
            end
        end
        idle();
        total++;
        if ({FlushCnt, MemWaitCnt} !== 8'd0) begin
            bad++; $display("FAIL sat_others fl=%0d mw=%0d want 0", FlushCnt, MemWaitCnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_flush();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
